// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: register-file write-port owner with index-fill init sequencer and A/B round-robin writeback arbiter
module regfile_wr_sched #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter bit DROP_XZR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t              state_q;
  logic [ADDR_W:0]     idx_q;
  logic                last_b_q;
  logic                rf_we_q;
  logic [ADDR_W-1:0]   rf_waddr_q;
  logic [DATA_W-1:0]   rf_wdata_q;
  logic                run, acc, fwd;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  always_comb begin
    run      = (state_q == RUN) & ~init_req;
    a_ready  = run & a_valid & (~b_valid | last_b_q);
    b_ready  = run & b_valid & (~a_valid | ~last_b_q);
    acc      = a_ready | b_ready;
    sel_addr = a_ready ? a_addr : b_addr;
    sel_data = a_ready ? a_data : b_data;
    fwd      = acc & ~(DROP_XZR && sel_addr == '1);
  end
  // idx_q carries one extra bit so the cycle after the last fill write is distinguishable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      idx_q      <= '0;
      last_b_q   <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (state_q == INIT) begin
      rf_we_q <= ~idx_q[ADDR_W];
      if (!idx_q[ADDR_W]) begin
        rf_waddr_q <= idx_q[ADDR_W-1:0];
        rf_wdata_q <= DATA_W'(idx_q[ADDR_W-1:0]);
        idx_q      <= idx_q + 1'b1;
      end else begin
        state_q <= RUN;
      end
    end else if (init_req) begin
      state_q <= INIT;
      idx_q   <= '0;
      rf_we_q <= 1'b0;
    end else begin
      rf_we_q <= fwd;
      if (fwd) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
      if (acc) last_b_q <= b_ready;
    end
  end
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = (state_q == RUN);
endmodule
